// File: rtl/pcie_rx_snoop.sv
// pcie_rx_snoop: passive tap on the PCIe AXIS RX stream.
// Copies qualifying TLPs into a 72-bit FIFO word stream.
module pcie_rx_snoop #(
   parameter bit FILTER_MWR = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             sys_rst_n,
   input  logic [63:0]      m_axis_rx_tdata,
   input  logic [7:0]       m_axis_rx_tkeep,
   input  logic             m_axis_rx_tlast,
   input  logic             m_axis_rx_tvalid,
   output logic             m_axis_rx_tready,
   input  logic             snoop_en,
   output logic [71:0]      din,
   output logic             wr_en,
   input  logic             full,
   input  logic             prog_full,
   output logic [7:0]       rx_pktcount,
   output logic [CNT_W-1:0] drop_count,
   output logic             overflow_err
);

   typedef enum logic [1:0] {IDLE, PASS, DROP, SKIP} state_t;

   state_t           state_q, state_d;
   logic             tready_q, tready_d;
   logic             wr_en_q, wr_en_d;
   logic [71:0]      din_q, din_d;
   logic [7:0]       pkt_q, pkt_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             ovf_q, ovf_d;

   logic             acc;
   logic             is_mwr;
   logic             qual;
   logic [71:0]      word;
   logic             unused_keep;

   // Only tkeep[0] and tkeep[4] carry information for 8'h0F/8'hFF beats.
   assign unused_keep = ^{m_axis_rx_tkeep[7:5], m_axis_rx_tkeep[3:1]};

   // Next-state, FIFO word and counter logic.
   always_comb begin
      state_d  = state_q;
      tready_d = 1'b1;
      wr_en_d  = 1'b0;
      din_d    = din_q;
      pkt_d    = pkt_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      acc      = m_axis_rx_tvalid & tready_q;
      is_mwr   = m_axis_rx_tdata[30] & (m_axis_rx_tdata[28:24] == 5'd0);
      qual     = snoop_en & (!FILTER_MWR | is_mwr);
      word     = {4'b0000, m_axis_rx_tkeep[4], m_axis_rx_tkeep[0],
                  m_axis_rx_tlast, 1'b0, m_axis_rx_tdata};
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               if (qual && !prog_full && !full) begin
                  wr_en_d   = 1'b1;
                  din_d     = word;
                  din_d[64] = 1'b1;
                  if (m_axis_rx_tlast) pkt_d = pkt_q + 8'd1;
                  else                 state_d = PASS;
               end else if (qual) begin
                  if (!(&drop_q)) drop_d = drop_q + CNT_W'(1);
                  if (!m_axis_rx_tlast) state_d = DROP;
               end else begin
                  if (!m_axis_rx_tlast) state_d = SKIP;
               end
            end
         end
         PASS: begin
            if (acc) begin
               if (full) begin
                  // Truncated TLP: consumer resyncs on next SOF.
                  ovf_d   = 1'b1;
                  state_d = m_axis_rx_tlast ? IDLE : DROP;
               end else begin
                  wr_en_d = 1'b1;
                  din_d   = word;
                  if (m_axis_rx_tlast) begin
                     pkt_d   = pkt_q + 8'd1;
                     state_d = IDLE;
                  end
               end
            end
         end
         DROP, SKIP: begin
            if (acc && m_axis_rx_tlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         state_q  <= IDLE;
         tready_q <= 1'b0;
         wr_en_q  <= 1'b0;
         din_q    <= '0;
         pkt_q    <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tready_q <= tready_d;
         wr_en_q  <= wr_en_d;
         din_q    <= din_d;
         pkt_q    <= pkt_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
      end
   end

   assign m_axis_rx_tready = tready_q;
   assign wr_en            = wr_en_q;
   assign din              = din_q;
   assign rx_pktcount      = pkt_q;
   assign drop_count       = drop_q;
   assign overflow_err     = ovf_q;

endmodule
